// File: rtl/clk_meter_pkg.sv
// Shared types and default sizing for the two-channel clock frequency meter.
// The FSM encoding is common to the top level and any debug/observation logic.
package clk_meter_pkg;

  localparam int DEF_GATE_CYCLES = 1000;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    RESULT  = 2'd3
  } meter_state_t;

endpackage

// File: rtl/edge_sync_counter.sv
// One measurement channel: synchronizes an asynchronous test clock into clk,
// detects its rising edges and counts them in a saturating counter.
module edge_sync_counter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tclk,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   edge_det;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       count_next;

  // sync_reg[0] is the metastability-exposed stage; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], tclk};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_reg[SYNC_STAGES-1] & ~prev_reg;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (cnt_en && edge_det && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign sat   = (count_reg == CNT_MAX);

endmodule

// File: rtl/clk_freq_meter.sv
// Two-channel clock frequency meter: counts tclk1/tclk2 edges over a gate of
// GATE_CYCLES clk cycles and reports both counts plus a faster/slower flag.
module clk_freq_meter
  import clk_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tclk1,
  input  logic             tclk2,
  output logic [CNT_W-1:0] freq1,
  output logic [CNT_W-1:0] freq2,
  output logic             l2h,
  output logic             valid,
  output logic             ovf
);

  localparam int TW = $clog2(GATE_CYCLES);
  localparam int AW = $clog2(SYNC_STAGES + 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [AW-1:0] ARM_LAST  = AW'(SYNC_STAGES);

  meter_state_t state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [AW-1:0] arm_reg, arm_next;
  logic          cnt_clr, cnt_en;

  logic [CNT_W-1:0] cnt1, cnt2;
  logic             sat1, sat2;

  logic [CNT_W-1:0] freq1_reg, freq2_reg;
  logic             l2h_reg, ovf_reg;
  logic             in_result;
  logic             l2h_now;

  edge_sync_counter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .tclk  (tclk1),
    .clr   (cnt_clr),
    .cnt_en(cnt_en),
    .count (cnt1),
    .sat   (sat1)
  );

  edge_sync_counter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ch2 (
    .clk   (clk),
    .rst_n (rst_n),
    .tclk  (tclk2),
    .clr   (cnt_clr),
    .cnt_en(cnt_en),
    .count (cnt2),
    .sat   (sat2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      arm_reg   <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      arm_reg   <= arm_next;
    end
  end

  // Counters only run in MEASURE; every other state holds them cleared, so an
  // abort or a finished window always starts the next gate from zero.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    arm_next   = arm_reg;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        arm_next   = '0;
        if (en) state_next = ARM;
      end
      ARM: begin
        timer_next = '0;
        if (!en) begin
          state_next = IDLE;
          arm_next   = '0;
        end else if (arm_reg == ARM_LAST) begin
          state_next = MEASURE;
          arm_next   = '0;
        end else begin
          arm_next = arm_reg + AW'(1);
        end
      end
      MEASURE: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (!en) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer_reg == GATE_LAST) begin
          state_next = RESULT;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      RESULT: begin
        timer_next = '0;
        arm_next   = '0;
        state_next = en ? MEASURE : IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
        arm_next   = '0;
      end
    endcase
  end

  assign in_result = (state_reg == RESULT);
  assign l2h_now   = (cnt1 > cnt2) ? 1'b0 : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq1_reg <= '0;
      freq2_reg <= '0;
      l2h_reg   <= 1'b1;
      ovf_reg   <= 1'b0;
    end else if (in_result) begin
      freq1_reg <= cnt1;
      freq2_reg <= cnt2;
      l2h_reg   <= l2h_now;
      ovf_reg   <= sat1 | sat2;
    end
  end

  // During RESULT the counters still hold the finished window, so they are
  // presented directly; the registers keep that result once counters clear.
  assign freq1 = in_result ? cnt1 : freq1_reg;
  assign freq2 = in_result ? cnt2 : freq2_reg;
  assign l2h   = in_result ? l2h_now : l2h_reg;
  assign ovf   = in_result ? (sat1 | sat2) : ovf_reg;
  assign valid = in_result;

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Synthesizable two-channel clock frequency meter and comparator.
- Counts rising edges of two asynchronous test clocks over a fixed gate window of reference-clock cycles.
- Reports both counts and a faster/slower flag, `l2h`, with the same polarity as the comparator stage it feeds: `l2h`=0 when channel 1 is faster, else 1.
- Sits directly upstream of the clock-select/compare logic and replaces simulation-only `$realtime` measurement with cycle-counted hardware.

Parameters:
- GATE_CYCLES, 1000, gate window length in `clk` cycles (≥2).
- CNT_W, 16, width of each edge counter and count output.
- SYNC_STAGES, 2, flip-flop depth of each test-clock synchronizer (≥2).

Ports:
- clk  input  1  reference clock; one clock for the whole block.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable, level-sensitive.
- tclk1  input  1  test clock 1, asynchronous to `clk`, frequency < f(clk)/2.
- tclk2  input  1  test clock 2, asynchronous to `clk`, frequency < f(clk)/2.
- freq1  output  CNT_W  edge count of `tclk1` in the last completed window.
- freq2  output  CNT_W  edge count of `tclk2` in the last completed window.
- l2h  output  1  0 if freq1 > freq2, else 1.
- valid  output  1  one-cycle pulse when new results are loaded.
- ovf  output  1  1 if either counter saturated in the last completed window.

Behaviour:
- Reset (`rst_n`=0, asynchronous): `freq1`=0, `freq2`=0, `l2h`=1 (equal-count rule), `valid`=0, `ovf`=0. Synchronizers, edge registers, counters and gate timer clear. FSM goes to IDLE.
- Synchronizer: SYNC_STAGES flip-flop chain per channel, then a previous-value register.
- Edge detect: edge = sync_out & ~prev.
- FSM states:
  - IDLE: counters held at 0. When `en`=1, go to ARM.
  - ARM: lasts SYNC_STAGES+1 cycles to flush the synchronizer and prev registers. Edges are ignored. Then go to MEASURE with gate timer = 0.
  - MEASURE: lasts exactly GATE_CYCLES cycles. Each cycle with a detected edge increments that channel's counter. On the last cycle (timer = GATE_CYCLES-1), go to RESULT. An edge detected in that last cycle is counted.
  - RESULT: lasts one cycle.
    - Load `freq1`/`freq2` from the counters.
    - `l2h` = (cnt1 > cnt2) ? 0 : 1.
    - `ovf` = either counter saturated.
    - Assert `valid`.
    - Clear counters and timer.
    - Next state is MEASURE if `en`=1, else IDLE. Back-to-back windows have no gap beyond the RESULT cycle.
- Result timing: outputs change and `valid`=1 on the cycle after the last gate cycle. Window period when running continuously is GATE_CYCLES+1 cycles.
- The edge in the RESULT cycle is not counted. This is a documented ±1 count measurement quantization.
- Counters saturate at 2^CNT_W-1; no wrap-around.
- `en` falling in ARM or MEASURE: abort to IDLE next cycle. Counters clear. Outputs hold the previous result. No `valid` pulse.
- `en` falling in RESULT: the result still completes with `valid`=1, then go to IDLE.
- Both channels detecting an edge in the same cycle: both counters increment independently.
- Test clock stopped: its count is 0 for that window. If both channels are stopped, `l2h`=1.
- `freq1`, `freq2`, `l2h`, `ovf` change only in RESULT or on reset.
- Gate timer width: $clog2(GATE_CYCLES).

Decomposition:
- Shared package clk_meter_pkg:
  - FSM state enum {IDLE, ARM, MEASURE, RESULT}.
  - Default constants for GATE_CYCLES, CNT_W, SYNC_STAGES.
- Sub-module edge_sync_counter, instantiated twice:
  - Synchronizer chain, prev register, edge detect.
  - Saturating CNT_W counter with inputs clr and cnt_en.
  - Outputs count and sat.
- Top level holds the FSM, gate timer, comparison and output registers.

Test Plan:
- GATE_CYCLES=100; tclk1 period 4 clk, tclk2 period 10 clk, `en`=1 → first `valid` pulse has freq1=25, freq2=10, l2h=0, ovf=0. The next window gives the same values, with the `valid` pulses 101 cycles apart.
- Same as above with the periods swapped → freq1=10, freq2=25, l2h=1.
- Both periods 5 clk, with different phases → freq1=freq2=20, l2h=1 (tie rule).
- CNT_W=4, tclk1 period 4, tclk2 stopped → freq1=15 (saturated), freq2=0, ovf=1, l2h=0.
- Drop `en` at cycle 50 of MEASURE → no `valid` pulse. Outputs keep the previous result. Re-raising `en` gives a full ARM+MEASURE and correct counts.
- Assert `rst_n`=0 mid-MEASURE, asynchronously between clock edges → outputs immediately become 0/0/l2h=1/valid=0/ovf=0. After release with `en`=1, the first `valid` pulse arrives SYNC_STAGES+1+GATE_CYCLES+1 cycles later.
